// File: rtl/cache_pkg.sv
// Shared definitions for the cache-to-SPI arbiter: FSM states, port ids, SPI opcodes, default widths.
package cache_pkg;

    localparam int DEF_ADDR_W = 24;
    localparam int DEF_LINE_W = 128;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arbState_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    function automatic logic [7:0] cmdFor(input logic isWrite);
        return isWrite ? CMD_WRITE : CMD_READ;
    endfunction

endpackage

// File: rtl/cache_spi_arbiter_rr_arb2.sv
// Two-input round-robin grant; the port not granted last wins a tie, last-grant resets to instruction.
module rr_arb2
    import cache_pkg::*;
(
    input  logic  iCLK,
    input  logic  iRST,
    input  logic  iReqI,
    input  logic  iReqD,
    input  logic  iUpdate,
    input  port_t iUpdPort,
    output logic  oGrantValid,
    output port_t oGrant
);

    port_t lastGrant;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            lastGrant <= PORT_I;
        end else if (iUpdate) begin
            lastGrant <= iUpdPort;
        end
    end

    always_comb begin
        oGrantValid = iReqI | iReqD;
        oGrant      = PORT_I;
        if (iReqD && (!iReqI || lastGrant == PORT_I)) begin
            oGrant = PORT_D;
        end
    end

endmodule

// File: rtl/cache_spi_arbiter.sv
// Shares one SPI line serializer between I-cache refill and D-cache refill/write-back.
// Optional watchdog abort enabled by defining CACHE_ARB_TIMEOUT_EN.
module cache_spi_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int LINE_W      = DEF_LINE_W,
    parameter int FRAME_W     = 8 + ADDR_W + LINE_W,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iIREQ,
    input  logic [ADDR_W-1:0]  iIADDR,
    output logic               oIACK,
    output logic [LINE_W-1:0]  oIDATA,
    input  logic               iDREQ,
    input  logic               iDWE,
    input  logic [ADDR_W-1:0]  iDADDR,
    input  logic [LINE_W-1:0]  iDWDATA,
    output logic               oDACK,
    output logic [LINE_W-1:0]  oDRDATA,
    output logic               oERR,
    output logic               oSERstart,
    output logic [FRAME_W-1:0] oSERdata,
    input  logic               iSERend,
    input  logic [FRAME_W-1:0] iSERdata
);

    arbState_t          state;
    arbState_t          stateNext;
    port_t              grantPort;
    logic               isWrite;
    logic [FRAME_W-1:0] frameReg;
    logic [LINE_W-1:0]  iDataReg;
    logic [LINE_W-1:0]  dDataReg;
    logic               grantValid;
    port_t              grantSel;
    logic               timeoutHit;
    logic               unusedSink;

    assign unusedSink = ^iSERdata[FRAME_W-1:LINE_W] ^ (TIMEOUT_CYC > 0);

    rr_arb2 uArb (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iReqI       (iIREQ),
        .iReqD       (iDREQ),
        .iUpdate     (state == ST_DONE),
        .iUpdPort    (grantPort),
        .oGrantValid (grantValid),
        .oGrant      (grantSel)
    );

`ifdef CACHE_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wdCnt;
    logic             errReg;

    // Fires on the WAIT cycle whose edge brings the count to TIMEOUT_CYC.
    assign timeoutHit = (state == ST_WAIT) && (wdCnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            wdCnt  <= '0;
            errReg <= 1'b0;
        end else if (state == ST_ISSUE) begin
            wdCnt  <= '0;
            errReg <= 1'b0;
        end else if (state == ST_WAIT) begin
            wdCnt <= wdCnt + 1'b1;
            if (timeoutHit && !iSERend) begin
                errReg <= 1'b1;
            end
        end
    end

    assign oERR = (state == ST_DONE) && errReg;
`else
    assign timeoutHit = 1'b0;
    assign oERR       = 1'b0;
`endif

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE:  if (grantValid) stateNext = ST_ISSUE;
            ST_ISSUE: stateNext = ST_WAIT;
            ST_WAIT:  if (iSERend || timeoutHit) stateNext = ST_DONE;
            ST_DONE:  stateNext = ST_IDLE;
            default:  stateNext = ST_IDLE;
        endcase
    end

    // Frame is latched at grant and held until the next grant.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            grantPort <= PORT_I;
            isWrite   <= 1'b0;
            frameReg  <= '0;
            iDataReg  <= '0;
            dDataReg  <= '0;
        end else begin
            if (state == ST_IDLE && grantValid) begin
                grantPort <= grantSel;
                if (grantSel == PORT_D) begin
                    isWrite  <= iDWE;
                    frameReg <= {cmdFor(iDWE), iDADDR, (iDWE ? iDWDATA : {LINE_W{1'b1}})};
                end else begin
                    isWrite  <= 1'b0;
                    frameReg <= {CMD_READ, iIADDR, {LINE_W{1'b1}}};
                end
            end
            if (state == ST_WAIT && iSERend) begin
                if (grantPort == PORT_I) begin
                    iDataReg <= iSERdata[LINE_W-1:0];
                end else if (!isWrite) begin
                    dDataReg <= iSERdata[LINE_W-1:0];
                end
            end
        end
    end

    assign oSERstart = (state == ST_ISSUE);
    assign oSERdata  = frameReg;
    assign oIACK     = (state == ST_DONE) && (grantPort == PORT_I);
    assign oDACK     = (state == ST_DONE) && (grantPort == PORT_D);
    assign oIDATA    = iDataReg;
    assign oDRDATA   = dDataReg;

endmodule

// File: tb/tb_cache_spi_arbiter.sv
// Self-checking bench for cache_spi_arbiter: table vectors, hand sequences and randomized traffic
// against a transaction-level model. Define CACHE_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_cache_spi_arbiter;

    localparam int ADDR_W  = 24;
    localparam int LINE_W  = 128;
    localparam int FRAME_W = 8 + ADDR_W + LINE_W;
    localparam int TMO     = 16;
    localparam logic [LINE_W-1:0] ONES = {LINE_W{1'b1}};

    logic               iCLK = 1'b0;
    logic               iRST;
    logic               iIREQ;
    logic [ADDR_W-1:0]  iIADDR;
    logic               oIACK;
    logic [LINE_W-1:0]  oIDATA;
    logic               iDREQ;
    logic               iDWE;
    logic [ADDR_W-1:0]  iDADDR;
    logic [LINE_W-1:0]  iDWDATA;
    logic               oDACK;
    logic [LINE_W-1:0]  oDRDATA;
    logic               oERR;
    logic               oSERstart;
    logic [FRAME_W-1:0] oSERdata;
    logic               iSERend;
    logic [FRAME_W-1:0] iSERdata;

    always #5 iCLK = ~iCLK;

    cache_spi_arbiter #(
        .ADDR_W      (ADDR_W),
        .LINE_W      (LINE_W),
        .FRAME_W     (FRAME_W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iIREQ     (iIREQ),
        .iIADDR    (iIADDR),
        .oIACK     (oIACK),
        .oIDATA    (oIDATA),
        .iDREQ     (iDREQ),
        .iDWE      (iDWE),
        .iDADDR    (iDADDR),
        .iDWDATA   (iDWDATA),
        .oDACK     (oDACK),
        .oDRDATA   (oDRDATA),
        .oERR      (oERR),
        .oSERstart (oSERstart),
        .oSERdata  (oSERdata),
        .iSERend   (iSERend),
        .iSERdata  (iSERdata)
    );

    int nVec = 0;
    int nMis = 0;

    // Transaction-level model: last served port (0 = I, 1 = D) and last line returned per port.
    bit                mLast;
    logic [LINE_W-1:0] mI;
    logic [LINE_W-1:0] mD;

    typedef struct {
        bit                 isD;
        bit                 we;
        logic [ADDR_W-1:0]  addr;
        logic [LINE_W-1:0]  wdata;
        logic [LINE_W-1:0]  line;
        int                 delay;
        logic [FRAME_W-1:0] expFrame;
        logic [LINE_W-1:0]  expData;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [FRAME_W-1:0] act, input logic [FRAME_W-1:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    function automatic logic [FRAME_W-1:0] expFrameOf(input bit isD);
        if (!isD) return {8'h03, iIADDR, ONES};
        return {(iDWE ? 8'h02 : 8'h03), iDADDR, (iDWE ? iDWDATA : ONES)};
    endfunction

    function automatic logic [LINE_W-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Called in an IDLE cycle with the winning request visible; ends in the IDLE cycle after the ack.
    task automatic serve(input bit isD, input logic [FRAME_W-1:0] expFrame, input logic [LINE_W-1:0] line,
                         input int delay, input logic [LINE_W-1:0] expData, input bit reraise);
        tick();
        chk("start", oSERstart, 1);
        chk("frame", oSERdata, expFrame);
        chk("noAckIssue", {oIACK, oDACK}, 0);
        for (int c = 1; c <= delay; c++) begin
            tick();
            chk("waitQuiet", {oIACK, oDACK, oSERstart}, 0);
        end
        iSERend  = 1'b1;
        iSERdata = {$urandom(), line};
        tick();
        iSERend = 1'b0;
        chk("ackPort", {oIACK, oDACK}, isD ? 2'b01 : 2'b10);
        chk("errLow", oERR, 0);
        chk("ackData", isD ? oDRDATA : oIDATA, expData);
        chk("frameHeld", oSERdata, expFrame);
        if (isD) iDREQ = 1'b0; else iIREQ = 1'b0;
        tick();
        chk("ackOnce", {oIACK, oDACK}, 0);
        $display("txn port=%s frame=%h data=%h", isD ? "D" : "I", expFrame, expData);
        if (reraise) begin
            if (isD) iDREQ = 1'b1; else iIREQ = 1'b1;
        end
    endtask

    task automatic modelAck(input bit isD, input bit we, input logic [LINE_W-1:0] line);
        mLast = isD;
        if (!isD) mI = line;
        else if (!we) mD = line;
    endtask

    initial begin
        bit                 win;
        bit                 exp4[5];
        logic [FRAME_W-1:0] f;
        logic [LINE_W-1:0]  ln;
        int                 dly;

        iRST = 1'b1; iIREQ = 0; iIADDR = '0; iDREQ = 0; iDWE = 0; iDADDR = '0; iDWDATA = '0;
        iSERend = 0; iSERdata = '0;
        mLast = 0; mI = '0; mD = '0;
        tick(); tick();
        chk("rstCtl", {oSERstart, oIACK, oDACK, oERR}, 0);
        chk("rstFrame", oSERdata, 0);
        chk("rstIData", oIDATA, 0);
        chk("rstDData", oDRDATA, 0);
        iRST = 1'b0;
        tick();

        tbl[0] = '{0, 0, 24'h000100, '0, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 3,
                   {8'h03, 24'h000100, ONES}, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF};
        tbl[1] = '{1, 1, 24'h0A0000, 128'h0123456789ABCDEF0123456789ABCDEF, 128'h5A5A5A5A_5A5A5A5A_5A5A5A5A_5A5A5A5A, 2,
                   {8'h02, 24'h0A0000, 128'h0123456789ABCDEF0123456789ABCDEF}, '0};
        tbl[2] = '{1, 0, 24'h123456, '0, 128'h00112233445566778899AABBCCDDEEFF, 1,
                   {8'h03, 24'h123456, ONES}, 128'h00112233445566778899AABBCCDDEEFF};
        tbl[3] = '{1, 1, 24'hFFFFFF, 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000, 128'h1, 6,
                   {8'h02, 24'hFFFFFF, 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000}, 128'h00112233445566778899AABBCCDDEEFF};
        tbl[4] = '{0, 0, 24'h000000, '0, '0, 1, {8'h03, 24'h000000, ONES}, '0};

        for (int v = 0; v < 5; v++) begin
            if (tbl[v].isD) begin
                iDREQ = 1; iDWE = tbl[v].we; iDADDR = tbl[v].addr; iDWDATA = tbl[v].wdata;
            end else begin
                iIREQ = 1; iIADDR = tbl[v].addr;
            end
            serve(tbl[v].isD, tbl[v].expFrame, tbl[v].line, tbl[v].delay, tbl[v].expData, 0);
            modelAck(tbl[v].isD, tbl[v].we, tbl[v].line);
        end

        // Tie with both held and re-raised: last grant was I, so D, I, D, I, D.
        exp4 = '{1, 0, 1, 0, 1};
        iIADDR = 24'h000200; iDADDR = 24'h000300; iDWE = 0;
        iIREQ = 1; iDREQ = 1;
        for (int t = 0; t < 5; t++) begin
            f  = expFrameOf(exp4[t]);
            ln = rnd128();
            serve(exp4[t], f, ln, $urandom_range(1, 4), ln, t < 3);
            modelAck(exp4[t], 0, ln);
        end

        // Reset during WAIT, then a tie must go to D again.
        iIREQ = 1; iIADDR = 24'h00ABCD;
        tick(); tick(); tick();
        iRST = 1'b1;
        #1;
        chk("midRstCtl", {oSERstart, oIACK, oDACK, oERR}, 0);
        chk("midRstFrame", oSERdata, 0);
        chk("midRstData", {oIDATA, oDRDATA}, 0);
        mI = '0; mD = '0; mLast = 0;
        iIREQ = 0;
        tick();
        iRST = 1'b0;
        iSERend = 1'b1;
        tick();
        iSERend = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("noAckAfterRst", {oIACK, oDACK, oSERstart}, 0);
        end
        iIREQ = 1; iDREQ = 1; iDWE = 0; iDADDR = 24'h000777;
        ln = rnd128();
        serve(1, expFrameOf(1), ln, 2, ln, 0);
        modelAck(1, 0, ln);
        ln = rnd128();
        serve(0, expFrameOf(0), ln, 1, ln, 0);
        modelAck(0, 0, ln);

        // Spurious end-of-transfer while idle.
        iSERend = 1'b1; iSERdata = {$urandom(), rnd128()};
        tick();
        iSERend = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("spuriousQuiet", {oIACK, oDACK, oSERstart}, 0);
        end
        chk("spuriousIData", oIDATA, mI);
        chk("spuriousDData", oDRDATA, mD);

        // Randomized traffic against the model.
        for (int r = 0; r < 40; r++) begin
            if (!iIREQ && ($urandom_range(0, 1) == 1)) begin
                iIREQ = 1; iIADDR = ADDR_W'($urandom());
            end
            if (!iDREQ && (($urandom_range(0, 1) == 1) || !iIREQ)) begin
                iDREQ = 1; iDWE = 1'($urandom()); iDADDR = ADDR_W'($urandom()); iDWDATA = rnd128();
            end
            win = (iIREQ && iDREQ) ? !mLast : iDREQ;
            f   = expFrameOf(win);
            ln  = rnd128();
            dly = $urandom_range(1, 8);
            serve(win, f, ln, dly, (win && iDWE) ? mD : ln, 0);
            modelAck(win, win && iDWE, ln);
        end
        if (iIREQ || iDREQ) begin
            win = (iIREQ && iDREQ) ? !mLast : iDREQ;
            ln  = rnd128();
            serve(win, expFrameOf(win), ln, 1, (win && iDWE) ? mD : ln, 0);
            modelAck(win, win && iDWE, ln);
        end
        if (iIREQ || iDREQ) begin
            win = iDREQ;
            ln  = rnd128();
            serve(win, expFrameOf(win), ln, 1, (win && iDWE) ? mD : ln, 0);
            modelAck(win, win && iDWE, ln);
        end

`ifdef CACHE_ARB_TIMEOUT_EN
        // Serializer never answers: abort ack with oERR at cycle 1+TMO+1.
        iIREQ = 1; iIADDR = 24'h0F0F0F;
        for (int c = 1; c <= TMO + 1; c++) begin
            tick();
            chk("tmoQuiet", {oIACK, oDACK, oERR}, 0);
        end
        tick();
        chk("tmoAck", {oIACK, oERR}, 2'b11);
        chk("tmoDataKept", oIDATA, mI);
        iIREQ = 0;
        tick();
        chk("tmoOnce", {oIACK, oDACK, oERR}, 0);
        $display("txn port=I timeout err=1");
        mLast = 0;
        iDREQ = 1; iDWE = 0; iDADDR = 24'h0000F0;
        ln = rnd128();
        serve(1, expFrameOf(1), ln, 3, ln, 0);
        modelAck(1, 0, ln);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
